// File: rtl/intpol2_iq_sched_pkg.sv
// intpol2_sched_pkg: shared FSM states, status bit indices and default pipeline latency
// for the I/Q interpolator sequencer.
package intpol2_sched_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_DRAIN, S_DONE} state_e;

    localparam int STATUS_DONE       = 0;
    localparam int STATUS_BUSY       = 1;
    localparam int STATUS_STOP_EMPTY = 2;
    localparam int STATUS_STOP_AFULL = 3;
    localparam int STATUS_BYPASS     = 5;

    localparam int PIPE_LAT_DEF = 3;

endpackage

// File: rtl/intpol2_iq_sched_dly.sv
// intpol2_sched_dly: LAT-deep valid delay line with synchronous clear; any_o flags bits in flight.
module intpol2_sched_dly #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o,
    output logic any_o
);

    logic [LAT-1:0] sr_q;
    logic [LAT:0]   sr_d;

    assign sr_d  = {sr_q, d_i};
    assign q_o   = sr_q[LAT-1];
    assign any_o = |sr_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) sr_q <= '0;
        else              sr_q <= sr_d[LAT-1:0];
    end

endmodule

// File: rtl/intpol2_iq_sched.sv
// intpol2_iq_sched: lockstep I/Q FIFO pop, core load/step sequencing and write-enable timing.
// Optional INTPOL2_SCHED_STATS_EN adds a saturating stall-cycle counter output.
module intpol2_iq_sched
    import intpol2_sched_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int RATIO_WIDTH = 4,
    parameter int PIPE_LAT    = PIPE_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   cfg_num_samples,
    input  logic [RATIO_WIDTH-1:0] cfg_ratio,
    input  logic                   cfg_bypass,
    input  logic                   Empty_I_i,
    input  logic                   Empty_Q_i,
    input  logic                   Afull_i,
    output logic                   Read_Enable_o,
    output logic                   load_o,
    output logic                   step_o,
    output logic                   Write_Enable_o,
    output logic [7:0]             status_o
`ifdef INTPOL2_SCHED_STATS_EN
    ,
    output logic [15:0]            stall_cnt_o
`endif
);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d, cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d, phase_q, phase_d;
    logic                   bypass_q, bypass_d, busy_q, busy_d, done_q, done_d;
    logic                   stop_empty, stop_afull, sr_any;

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        cnt_d         = cnt_q;
        ratio_d       = ratio_q;
        phase_d       = phase_q;
        bypass_d      = bypass_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        Read_Enable_o = 1'b0;
        load_o        = 1'b0;
        step_o        = 1'b0;
        stop_empty    = 1'b0;
        stop_afull    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                num_d    = cfg_num_samples;
                ratio_d  = (cfg_bypass || cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
                bypass_d = cfg_bypass;
                busy_d   = 1'b1;
                cnt_d    = '0;
                state_d  = (cfg_num_samples == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                Read_Enable_o = !Empty_I_i && !Empty_Q_i;
                stop_empty    = !Read_Enable_o;
                state_d       = Read_Enable_o ? S_LOAD : S_FETCH;
            end
            S_LOAD: begin
                load_o  = 1'b1;
                phase_d = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                step_o     = !Afull_i;
                stop_afull = Afull_i;
                if (step_o) begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == ratio_q - 1'b1) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_d == num_q) ? S_DRAIN : S_FETCH;
                    end
                end
            end
            S_DRAIN: state_d = sr_any ? S_DRAIN : S_DONE;
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            cnt_q    <= '0;
            ratio_q  <= '0;
            phase_q  <= '0;
            bypass_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            phase_q  <= phase_d;
            bypass_q <= bypass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    intpol2_sched_dly #(.LAT(PIPE_LAT)) u_dly (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .d_i   (step_o),
        .q_o   (Write_Enable_o),
        .any_o (sr_any)
    );

    always_comb begin
        status_o                    = '0;
        status_o[STATUS_DONE]       = done_q;
        status_o[STATUS_BUSY]       = busy_q;
        status_o[STATUS_STOP_EMPTY] = stop_empty;
        status_o[STATUS_STOP_AFULL] = stop_afull;
        status_o[STATUS_BYPASS]     = bypass_q;
    end

`ifdef INTPOL2_SCHED_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || (start && state_q == S_IDLE))                         stall_q <= '0;
        else if (busy_q && (stop_empty || stop_afull) && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_intpol2_iq_sched.sv
// tb_intpol2_iq_sched: directed scenarios for the I/Q sequencer with hand-computed counts and latencies.
module tb_intpol2_iq_sched;

    localparam int CW = 16;
    localparam int RW = 4;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_bypass = 1'b0;
    logic          Empty_I_i = 1'b0, Empty_Q_i = 1'b0, Afull_i = 1'b0;
    logic [CW-1:0] cfg_num_samples = '0;
    logic [RW-1:0] cfg_ratio = '0;
    logic          Read_Enable_o, load_o, step_o, Write_Enable_o;
    logic [7:0]    status_o;
`ifdef INTPOL2_SCHED_STATS_EN
    logic [15:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    intpol2_iq_sched #(.CNT_WIDTH(CW), .RATIO_WIDTH(RW), .PIPE_LAT(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_samples (cfg_num_samples),
        .cfg_ratio       (cfg_ratio),
        .cfg_bypass      (cfg_bypass),
        .Empty_I_i       (Empty_I_i),
        .Empty_Q_i       (Empty_Q_i),
        .Afull_i         (Afull_i),
        .Read_Enable_o   (Read_Enable_o),
        .load_o          (load_o),
        .step_o          (step_o),
        .Write_Enable_o  (Write_Enable_o),
        .status_o        (status_o)
`ifdef INTPOL2_SCHED_STATS_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int t_re = 0, t_ld = 0, t_st = 0, t_we = 0, t_dn = 0, t_se = 0, t_sa = 0;
    int b_re, b_ld, b_st, b_we, b_dn, b_se, b_sa;
    int start_cyc = 0, we_first = 0, done_cyc = 0;
    logic we_seen = 1'b1, done_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Running event totals and latency markers, sampled mid-cycle
    always @(negedge clk) begin
        t_re <= t_re + int'(Read_Enable_o);
        t_ld <= t_ld + int'(load_o);
        t_st <= t_st + int'(step_o);
        t_we <= t_we + int'(Write_Enable_o);
        t_dn <= t_dn + int'(status_o[0]);
        t_se <= t_se + int'(status_o[2]);
        t_sa <= t_sa + int'(status_o[3]);
        if (start && !status_o[1]) begin
            start_cyc <= cyc;
            we_seen   <= 1'b0;
        end else if (Write_Enable_o && !we_seen) begin
            we_seen  <= 1'b1;
            we_first <= cyc;
        end
        if (status_o[0]) begin
            done_cyc  <= cyc;
            done_busy <= status_o[1];
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic snap();
        b_re = t_re; b_ld = t_ld; b_st = t_st; b_we = t_we;
        b_dn = t_dn; b_se = t_se; b_sa = t_sa;
    endtask

    task automatic pulse(input int num, input int ratio, input logic byp);
        @(posedge clk); #1;
        start = 1'b1; cfg_num_samples = CW'(num); cfg_ratio = RW'(ratio); cfg_bypass = byp;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (t_dn == b_dn && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, int'(t_dn != b_dn), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic deltas(input string tag, input int re, input int ld, input int st, input int we, input int dn);
        chk({tag, "_pops"},  t_re - b_re, re);
        chk({tag, "_loads"}, t_ld - b_ld, ld);
        chk({tag, "_steps"}, t_st - b_st, st);
        chk({tag, "_we"},    t_we - b_we, we);
        chk({tag, "_done"},  t_dn - b_dn, dn);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", int'({Read_Enable_o, load_o, step_o, Write_Enable_o, status_o}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: four pairs, ratio 2, no stalls
        snap();
        pulse(4, 2, 1'b0);
        @(negedge clk);
        chk("t1_busy", int'(status_o[1]), 1);
        chk("t1_first_pop", int'(Read_Enable_o), 1);
        wait_done("t1");
        deltas("t1", 4, 4, 8, 8, 1);
        chk("t1_we_lat", we_first - start_cyc, 6);
        chk("t1_done_lat", done_cyc - start_cyc, 22);
        chk("t1_busy_at_done", int'(done_busy), 0);

        // 2: downstream almost-full for 5 cycles after the 2nd step
        snap();
        pulse(2, 3, 1'b0);
        repeat (4) @(posedge clk);
        #1 Afull_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_step_held", int'(step_o), 0);
            chk("t2_stop_afull", int'(status_o[3]), 1);
            @(posedge clk); #1;
        end
        Afull_i = 1'b0;
        @(negedge clk);
        chk("t2_resume", int'(step_o), 1);
        wait_done("t2");
        deltas("t2", 2, 2, 6, 6, 1);
        chk("t2_afull_cycles", t_sa - b_sa, 5);
        chk("t2_done_lat", done_cyc - start_cyc, 21);
`ifdef INTPOL2_SCHED_STATS_EN
        chk("t2_stall_cnt", int'(stall_cnt_o), 5);
`endif

        // 3: Q FIFO empty for 4 cycles, I FIFO ready
        Empty_Q_i = 1'b1;
        snap();
        pulse(1, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_no_pop", int'(Read_Enable_o), 0);
            chk("t3_stop_empty", int'(status_o[2]), 1);
            @(posedge clk); #1;
        end
        Empty_Q_i = 1'b0;
        @(negedge clk);
        chk("t3_pop", int'(Read_Enable_o), 1);
        wait_done("t3");
        deltas("t3", 1, 1, 1, 1, 1);
        chk("t3_empty_cycles", t_se - b_se, 4);
`ifdef INTPOL2_SCHED_STATS_EN
        chk("t3_stall_cnt", int'(stall_cnt_o), 4);
`endif

        // 4: zero samples, ratio 0, bypass
        snap();
        pulse(0, 3, 1'b0);
        wait_done("t4a");
        deltas("t4a", 0, 0, 0, 0, 1);
        chk("t4a_done_lat", done_cyc - start_cyc, 2);
        snap();
        pulse(2, 0, 1'b0);
        wait_done("t4b");
        deltas("t4b", 2, 2, 2, 2, 1);
        chk("t4b_bypass_bit", int'(status_o[5]), 0);
        snap();
        pulse(2, 5, 1'b1);
        @(negedge clk);
        chk("t4c_bypass_run", int'(status_o[5]), 1);
        wait_done("t4c");
        deltas("t4c", 2, 2, 2, 2, 1);
        chk("t4c_bypass_held", int'(status_o[5]), 1);

        // 5: reset in the middle of EMIT, then a clean run
        snap();
        pulse(3, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_in_emit", int'(step_o), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_outputs", int'({Read_Enable_o, load_o, step_o, Write_Enable_o, status_o}), 0);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_done", t_dn - b_dn, 0);
        snap();
        pulse(2, 2, 1'b0);
        wait_done("t5");
        deltas("t5", 2, 2, 4, 4, 1);
        chk("t5_we_lat", we_first - start_cyc, 6);

        // 6: start re-pulsed while busy is ignored
        snap();
        pulse(3, 2, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1, 5, 1'b1);
        wait_done("t6");
        deltas("t6", 3, 3, 6, 6, 1);
        chk("t6_bypass_bit", int'(status_o[5]), 0);
        chk("t6_done_lat", done_cyc - start_cyc, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
